// File: rtl/max_block_sequencer.sv
// Block-peak sequencer: collects N bytes over a 4-phase dav_/rfd handshake,
// tracks their running maximum, and hands the result to a consumer.

module max_cmp (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] max
);
  assign max = (y > x) ? y : x;
endmodule

module max_block_sequencer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic [W-1:0] in_data,
  input  logic         dav_in_,
  output logic         rfd_in,
  output logic [W-1:0] out_max,
  output logic         dav_out_,
  input  logic         rfd_out,
  output logic         busy
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  typedef enum logic [1:0] {
    S_WAIT_DAV,
    S_WAIT_DAV_HIGH,
    S_OUT_ACK,
    S_OUT_END
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic           rfd_in_q, rfd_in_d;
  logic           dav_out_q, dav_out_d;
  logic [W-1:0]   out_max_q, out_max_d;
  logic [W-1:0]   cmp_max;

  max_cmp u_max (
    .x  (acc_q),
    .y  (in_data),
    .max(cmp_max)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    rfd_in_d  = rfd_in_q;
    dav_out_d = dav_out_q;
    out_max_d = out_max_q;
    case (state_q)
      S_WAIT_DAV: begin
        if (!dav_in_) begin
          // first sample of a block seeds acc directly
          acc_d    = (count_q == '0) ? in_data : cmp_max;
          if (count_q != N_C) count_d = count_q + CW'(1);
          rfd_in_d = 1'b0;
          state_d  = S_WAIT_DAV_HIGH;
        end
      end
      S_WAIT_DAV_HIGH: begin
        if (dav_in_) begin
          if (count_q == N_C) begin
            out_max_d = acc_q;
            dav_out_d = 1'b0;
            state_d   = S_OUT_ACK;
          end else begin
            rfd_in_d = 1'b1;
            state_d  = S_WAIT_DAV;
          end
        end
      end
      S_OUT_ACK: begin
        if (!rfd_out) begin
          dav_out_d = 1'b1;
          state_d   = S_OUT_END;
        end
      end
      S_OUT_END: begin
        // producer stays stalled until the consumer finishes its handshake
        if (rfd_out) begin
          count_d  = '0;
          acc_d    = '0;
          rfd_in_d = 1'b1;
          state_d  = S_WAIT_DAV;
        end
      end
      default: state_d = S_WAIT_DAV;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q   <= S_WAIT_DAV;
      acc_q     <= '0;
      count_q   <= '0;
      rfd_in_q  <= 1'b1;
      dav_out_q <= 1'b1;
      out_max_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      rfd_in_q  <= rfd_in_d;
      dav_out_q <= dav_out_d;
      out_max_q <= out_max_d;
    end
  end

  assign rfd_in   = rfd_in_q;
  assign dav_out_ = dav_out_q;
  assign out_max  = out_max_q;
  assign busy     = (state_q != S_WAIT_DAV);

endmodule

// File: tb/tb_max_block_sequencer.sv
// Directed bench for max_block_sequencer: handshaked blocks with hand-computed
// maxima, producer stall, asynchronous mid-block reset and a slow consumer.

module tb_max_block_sequencer;
  logic       clock = 1'b0;
  logic       reset_;
  logic [7:0] in_data;
  logic       dav_in_;
  logic       rfd_in;
  logic [7:0] out_max;
  logic       dav_out_;
  logic       rfd_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  max_block_sequencer #(.N(4), .W(8)) dut (
    .clock   (clock),
    .reset_  (reset_),
    .in_data (in_data),
    .dav_in_ (dav_in_),
    .rfd_in  (rfd_in),
    .out_max (out_max),
    .dav_out_(dav_out_),
    .rfd_out (rfd_out),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wait_rfd_in(input logic lvl, input string tag);
    int n = 0;
    while (rfd_in !== lvl && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 32'(rfd_in), 32'(lvl));
  endtask

  task automatic wait_dav_out(input logic lvl, input string tag);
    int n = 0;
    while (dav_out_ !== lvl && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 32'(dav_out_), 32'(lvl));
  endtask

  task automatic send(input logic [7:0] v);
    wait_rfd_in(1'b1, "send_rdy");
    in_data = v;
    dav_in_ = 1'b0;
    wait_rfd_in(1'b0, "send_cap");
    dav_in_ = 1'b1;
    in_data = 8'hxx;
    @(negedge clock);
  endtask

  task automatic send_block(input logic [7:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic recv(input logic [7:0] exp, input string tag);
    wait_dav_out(1'b0, tag);
    check({tag, "_max"}, 32'(out_max), 32'(exp));
    check({tag, "_rfd_in_stall"}, 32'(rfd_in), 32'd0);
    rfd_out = 1'b0;
    wait_dav_out(1'b1, tag);
    rfd_out = 1'b1;
    @(negedge clock);
    check({tag, "_rfd_in_after"}, 32'(rfd_in), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int bad;
    reset_  = 1'b0;
    in_data = 8'h00;
    dav_in_ = 1'b1;
    rfd_out = 1'b1;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    check("rst_rfd_in", 32'(rfd_in), 32'd1);
    check("rst_dav_out", 32'(dav_out_), 32'd1);
    check("rst_out_max", 32'(out_max), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    send_block(8'd10, 8'd5, 8'd200, 8'd7);
    recv(8'd200, "blk_mixed");
    check("idle_busy", 32'(busy), 32'd0);

    send_block(8'd254, 8'd255, 8'd255, 8'd0);
    recv(8'd255, "blk_top");
    send_block(8'd0, 8'd0, 8'd0, 8'd0);
    recv(8'd0, "blk_zero");

    // producer offers 99 while the result is still pending
    send_block(8'd10, 8'd10, 8'd10, 8'd10);
    wait_dav_out(1'b0, "blk_eq");
    check("blk_eq_max", 32'(out_max), 32'd10);
    in_data = 8'd99;
    dav_in_ = 1'b0;
    repeat (3) @(negedge clock);
    check("stall_rfd_in", 32'(rfd_in), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    rfd_out = 1'b0;
    wait_dav_out(1'b1, "stall_ack");
    rfd_out = 1'b1;
    @(negedge clock);
    check("stall_release", 32'(rfd_in), 32'd1);
    wait_rfd_in(1'b0, "stall_cap");
    dav_in_ = 1'b1;
    @(negedge clock);
    send(8'd1); send(8'd2); send(8'd3);
    recv(8'd99, "blk_carry");

    // asynchronous reset between clock edges, mid-block
    send(8'd50); send(8'd60);
    @(negedge clock);
    #2 reset_ = 1'b0;
    #1;
    check("mid_rst_rfd_in", 32'(rfd_in), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_max", 32'(out_max), 32'd0);
    #1 reset_ = 1'b1;
    @(negedge clock);
    send_block(8'd1, 8'd2, 8'd3, 8'd4);

    // slow consumer: result must hold while rfd_out stays high
    wait_dav_out(1'b0, "slow");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dav_out_ !== 1'b0 || out_max !== 8'd4) bad++;
    end
    check("slow_stable", 32'(bad), 32'd0);
    check("slow_max", 32'(out_max), 32'd4);
    rfd_out = 1'b0;
    @(negedge clock);
    check("slow_dav_rise", 32'(dav_out_), 32'd1);
    rfd_out = 1'b1;
    @(negedge clock);
    check("slow_retain", 32'(out_max), 32'd4);
    check("slow_rfd_in", 32'(rfd_in), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
